pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
// Central sequencer for the 5-stage pipeline. Owns the run/drain/done lifecycle, PC enable and PC-source select.
// Drives stall/flush to the IF_ID, ID_EX and EX_MEM registers, and EX-stage forwarding selects.
// Priority among taken branches (M), jumps and jr (D) and load-use hazards is fixed here.
// Replaces the delay-based branch/jump always-blocks and the halt counter in the top level; pure clocked control.
// PARAMETERS
// DRAIN_CYCLES  4   cycles held in DRAIN after halt word reaches D (lets E/M/W retire)
// CNT_W         32  width of cycle_count
// PORTS
// CLK          in   1      system clock, rising edge
// RESET_N      in   1      asynchronous active-low reset
// start        in   1      1-cycle pulse; leaves IDLE
// halt_D       in   1      instr_D == 32'hFFFF_FFFF
// jump_D       in   1      j/jal decoded in D
// jr_D         in   1      jr decoded in D
// uses_rt_D    in   1      D instruction reads rt as a source
// rs_D, rt_D   in   5      D source register numbers
// rs_E, rt_E   in   5      E source register numbers
// RegWrite_E   in   1      E writes a register
// MemtoReg_E   in   1      E is a load
// WriteReg_E   in   5      E destination register
// RegWrite_M   in   1      M writes a register
// WriteReg_M   in   5      M destination register
// taken_M      in   1      zero_M & Branch_M
// RegWrite_W   in   1      W writes a register
// WriteReg_W   in   5      W destination register
// pc_en        out  1      PC register load enable
// pc_sel       out  2      0 PC+4, 1 PCBranch_M, 2 jump target, 3 RD1_D (jr)
// stall_D      out  1      hold IF_ID contents
// flush_D      out  1      clear IF_ID at next edge
// flush_E      out  1      clear ID_EX at next edge (bubble)
// flush_M      out  1      clear EX_MEM at next edge
// fwdA_E       out  2      SrcA select: 0 RD1_E, 1 Result_W, 2 ALUOut_M
// fwdB_E       out  2      SrcB select, same encoding
// done         out  1      registered; high in DONE
// cycle_count  out  CNT_W  registered; cycles spent in RUN and DRAIN
// BEHAVIOUR
// - States IDLE, RUN, DRAIN, DONE.
// - Async reset -> IDLE, drain counter 0, cycle_count 0, done 0.
// - IDLE: pc_en 0, stall_D 1, flushes 0, pc_sel 0. start -> RUN next edge.
// - RUN, first matching rule wins (lower rules ignored that cycle):
//   1. taken_M: pc_sel 1, pc_en 1, flush_D/E/M 1. Clears jump/jr/load-use/halt seen in D this cycle.
//   2. halt_D: -> DRAIN; pc_en 0, stall_D 1, flush_E 1. Halt word never enters E.
//   3. load-use: MemtoReg_E & RegWrite_E & WriteReg_E!=0 & (WriteReg_E==rs_D | uses_rt_D & WriteReg_E==rt_D).
//      Response: pc_en 0, stall_D 1, flush_E 1 (exactly one bubble per hazard).
//   4. jr_D & rs_D!=0 & rs_D matches a RegWrite E or M destination: same stall as rule 3. Max 2 cycles.
//   5. jr_D otherwise: pc_sel 3, pc_en 1, flush_D 1.
//   6. jump_D: pc_sel 2, pc_en 1, flush_D 1. jal link write is not done here.
//   7. else: pc_sel 0, pc_en 1, all stall/flush 0.
// - DRAIN: pc_en 0, stall_D 1, flush_E 1 every cycle.
//   Counter increments; on reaching DRAIN_CYCLES-1 -> DONE next edge.
//   taken_M is ignored in DRAIN (older branch cannot follow halt).
// - DONE: done 1, pc_en 0, stall_D 1, flush_E 1. Stays in DONE until reset; start is ignored.
// - cycle_count += 1 on each edge in RUN or DRAIN. Saturates at all-ones, no wrap. Frozen in IDLE/DONE.
// - Forwarding is combinational in every state:
//   - fwdA_E = 2 if RegWrite_M & WriteReg_M!=0 & WriteReg_M==rs_E.
//   - Else fwdA_E = 1 if RegWrite_W & WriteReg_W!=0 & WriteReg_W==rs_E.
//   - Else fwdA_E = 0. fwdB_E is identical, using rt_E. M beats W on a double match.
// - Reset asserted mid-run: immediate IDLE. Count and done are cleared, all outputs take IDLE values.
// STRUCTURE
// - Shared package hazard_pkg: state encoding, and PC_SEL_PC4/BRANCH/JUMP/JR and FWD_RF/WB/MEM constants.
// - One natural sub-module: fwd_unit, the combinational forwarding compare (instantiated once, used for both A and B).
// - FSM, drain counter and cycle counter live in the top of this block.
// TESTING
// 1. Reset, start; plain ALU stream, no hazards -> pc_en 1 and pc_sel 0 every cycle. cycle_count==N after N RUN cycles.
// 2. lw $2 in E, add $3,$2,$4 in D -> exactly 1 cycle: pc_en 0, stall_D 1, flush_E 1. Then normal flow; fwdA_E==1 when add reaches E.
// 3. taken_M with jump_D and halt_D both high the same cycle -> pc_sel 1, flush_D/E/M all 1, state remains RUN.
// 4. jr $31 in D, RegWrite_E with WriteReg_E=31 -> 2 stall cycles, then pc_sel 3 with flush_D 1. jr $0 -> no stall.
// 5. halt_D in RUN with DRAIN_CYCLES=4 -> 4 DRAIN cycles, then done 1; cycle_count frozen; a further start pulse ignored.
// 6. RESET_N low mid-DRAIN -> next sample shows IDLE: done 0, cycle_count 0, pc_en 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: lifecycle states,
// PC source selects and EX-stage forwarding selects.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] PC_SEL_PC4    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
    localparam logic [1:0] PC_SEL_JR     = 2'd3;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    // Pick the youngest producer of src; M is younger than W so it wins.
    function automatic logic [1:0] fwd_pick(
        input logic [4:0] src,
        input logic       rw_m,
        input logic [4:0] wr_m,
        input logic       rw_w,
        input logic [4:0] wr_w
    );
        if (rw_m && (wr_m != 5'd0) && (wr_m == src)) return FWD_MEM;
        if (rw_w && (wr_w != 5'd0) && (wr_w == src)) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage forwarding compare for both ALU operands. Purely combinational;
// $0 is never forwarded since it is hardwired to zero.
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_E,
    input  logic [4:0] rt_E,
    input  logic       RegWrite_M,
    input  logic [4:0] WriteReg_M,
    input  logic       RegWrite_W,
    input  logic [4:0] WriteReg_W,
    output logic [1:0] fwdA_E,
    output logic [1:0] fwdB_E
);

    // Same priority rule applied independently to rs and rt.
    always_comb begin
        fwdA_E = fwd_pick(rs_E, RegWrite_M, WriteReg_M, RegWrite_W, WriteReg_W);
        fwdB_E = fwd_pick(rt_E, RegWrite_M, WriteReg_M, RegWrite_W, WriteReg_W);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline: run/drain/done lifecycle,
// PC enable and source select, stage stall/flush and EX forwarding.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
)
(
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             start,
    input  logic             halt_D,
    input  logic             jump_D,
    input  logic             jr_D,
    input  logic             uses_rt_D,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [4:0]       rs_E,
    input  logic [4:0]       rt_E,
    input  logic             RegWrite_E,
    input  logic             MemtoReg_E,
    input  logic [4:0]       WriteReg_E,
    input  logic             RegWrite_M,
    input  logic [4:0]       WriteReg_M,
    input  logic             taken_M,
    input  logic             RegWrite_W,
    input  logic [4:0]       WriteReg_W,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             stall_D,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic [1:0]       fwdA_E,
    output logic [1:0]       fwdB_E,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    logic load_use;
    logic jr_wait;

    fwd_unit u_fwd (
        .rs_E       (rs_E),
        .rt_E       (rt_E),
        .RegWrite_M (RegWrite_M),
        .WriteReg_M (WriteReg_M),
        .RegWrite_W (RegWrite_W),
        .WriteReg_W (WriteReg_W),
        .fwdA_E     (fwdA_E),
        .fwdB_E     (fwdB_E)
    );

    // Hazard detection in D: load result not yet available, or jr target
    // register still being produced in E or M.
    always_comb begin
        load_use = MemtoReg_E && RegWrite_E && (WriteReg_E != 5'd0) &&
                   ((WriteReg_E == rs_D) || (uses_rt_D && (WriteReg_E == rt_D)));
        jr_wait  = jr_D && (rs_D != 5'd0) &&
                   ((RegWrite_E && (WriteReg_E == rs_D)) ||
                    (RegWrite_M && (WriteReg_M == rs_D)));
    end

    // Next state and per-cycle pipeline control; first matching RUN rule wins.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        pc_en   = 1'b0;
        pc_sel  = PC_SEL_PC4;
        stall_D = 1'b1;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_M = 1'b0;
        case (state_q)
            ST_IDLE: begin
                drain_d = '0;
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                drain_d = '0;
                if (taken_M) begin
                    // Branch resolved in M squashes everything younger.
                    pc_en   = 1'b1;
                    pc_sel  = PC_SEL_BRANCH;
                    stall_D = 1'b0;
                    flush_D = 1'b1;
                    flush_E = 1'b1;
                    flush_M = 1'b1;
                end else if (halt_D) begin
                    // Halt word is held in D and never issued.
                    flush_E = 1'b1;
                    state_d = ST_DRAIN;
                end else if (load_use || jr_wait) begin
                    flush_E = 1'b1;
                end else if (jr_D) begin
                    pc_en   = 1'b1;
                    pc_sel  = PC_SEL_JR;
                    stall_D = 1'b0;
                    flush_D = 1'b1;
                end else if (jump_D) begin
                    pc_en   = 1'b1;
                    pc_sel  = PC_SEL_JUMP;
                    stall_D = 1'b0;
                    flush_D = 1'b1;
                end else begin
                    pc_en   = 1'b1;
                    stall_D = 1'b0;
                end
            end
            ST_DRAIN: begin
                flush_E = 1'b1;
                if (drain_q == DRAIN_LAST) state_d = ST_DONE;
                else                       drain_d = drain_q + 1'b1;
            end
            default: begin
                flush_E = 1'b1;
            end
        endcase
    end

    // Saturating active-cycle counter; frozen outside RUN/DRAIN.
    always_comb begin
        count_d = count_q;
        if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && (count_q != '1))
            count_d = count_q + CNT_W'(1);
        done_d = (state_d == ST_DONE);
    end

    // State, drain counter, cycle counter and done flag registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign done        = done_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl. The driver applies
// one stimulus per cycle just after the rising edge and queues the expected
// outputs from a lifecycle model; the monitor compares on the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam int DC = 4;
    localparam int CW = 32;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          start = 1'b0, halt_D = 1'b0, jump_D = 1'b0, jr_D = 1'b0, uses_rt_D = 1'b0;
    logic [4:0]    rs_D = '0, rt_D = '0, rs_E = '0, rt_E = '0;
    logic          RegWrite_E = 1'b0, MemtoReg_E = 1'b0;
    logic [4:0]    WriteReg_E = '0;
    logic          RegWrite_M = 1'b0;
    logic [4:0]    WriteReg_M = '0;
    logic          taken_M = 1'b0, RegWrite_W = 1'b0;
    logic [4:0]    WriteReg_W = '0;
    logic          pc_en, stall_D, flush_D, flush_E, flush_M, done;
    logic [1:0]    pc_sel, fwdA_E, fwdB_E;
    logic [CW-1:0] cycle_count;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .start(start), .halt_D(halt_D),
        .jump_D(jump_D), .jr_D(jr_D), .uses_rt_D(uses_rt_D),
        .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
        .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .WriteReg_E(WriteReg_E),
        .RegWrite_M(RegWrite_M), .WriteReg_M(WriteReg_M), .taken_M(taken_M),
        .RegWrite_W(RegWrite_W), .WriteReg_W(WriteReg_W),
        .pc_en(pc_en), .pc_sel(pc_sel), .stall_D(stall_D), .flush_D(flush_D),
        .flush_E(flush_E), .flush_M(flush_M), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
        .done(done), .cycle_count(cycle_count)
    );

    typedef struct packed {
        logic       rst;
        logic       start, halt, jump, jr, uses_rt;
        logic [4:0] rs_D, rt_D, rs_E, rt_E;
        logic       rw_E, m2r_E;
        logic [4:0] wr_E;
        logic       rw_M;
        logic [4:0] wr_M;
        logic       taken;
        logic       rw_W;
        logic [4:0] wr_W;
    } stim_t;

    typedef struct packed {
        logic          pc_en;
        logic [1:0]    pc_sel;
        logic          stall_D, flush_D, flush_E, flush_M;
        logic [1:0]    fwdA, fwdB;
        logic          done;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Model of the lifecycle: phase, remaining drain cycles, active-cycle tally.
    int          m_mode  = M_IDLE;
    int          m_drain = 0;
    longint      m_cnt   = 0;
    longint      CNT_MAX = (64'd1 << CW) - 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [4:0] src, input stim_t s);
        // Most recent writer of src supplies the value.
        if (s.rw_M && s.wr_M != 0 && s.wr_M == src) return 2'd2;
        if (s.rw_W && s.wr_W != 0 && s.wr_W == src) return 2'd1;
        return 2'd0;
    endfunction

    function automatic stim_t rnd_stim(input int halt_pct);
        stim_t s;
        s         = '0;
        s.start   = ($urandom_range(0, 3) == 0);
        s.halt    = ($urandom_range(0, 99) < halt_pct);
        s.jump    = ($urandom_range(0, 5) == 0);
        s.jr      = ($urandom_range(0, 5) == 0);
        s.uses_rt = $urandom_range(0, 1);
        s.rs_D    = 5'($urandom_range(0, 3));
        s.rt_D    = 5'($urandom_range(0, 3));
        s.rs_E    = 5'($urandom_range(0, 3));
        s.rt_E    = 5'($urandom_range(0, 3));
        s.rw_E    = $urandom_range(0, 1);
        s.m2r_E   = ($urandom_range(0, 2) == 0);
        s.wr_E    = 5'($urandom_range(0, 3));
        s.rw_M    = $urandom_range(0, 1);
        s.wr_M    = 5'($urandom_range(0, 3));
        s.taken   = ($urandom_range(0, 7) == 0);
        s.rw_W    = $urandom_range(0, 1);
        s.wr_W    = 5'($urandom_range(0, 3));
        return s;
    endfunction

    // Apply one cycle of stimulus, queue its expected response, advance model.
    task automatic step(input stim_t s);
        exp_t e;
        logic lu, jw;
        @(posedge CLK);
        #1;
        RESET_N = !s.rst;
        start = s.start; halt_D = s.halt; jump_D = s.jump; jr_D = s.jr; uses_rt_D = s.uses_rt;
        rs_D = s.rs_D; rt_D = s.rt_D; rs_E = s.rs_E; rt_E = s.rt_E;
        RegWrite_E = s.rw_E; MemtoReg_E = s.m2r_E; WriteReg_E = s.wr_E;
        RegWrite_M = s.rw_M; WriteReg_M = s.wr_M; taken_M = s.taken;
        RegWrite_W = s.rw_W; WriteReg_W = s.wr_W;

        if (s.rst) begin
            m_mode = M_IDLE; m_drain = 0; m_cnt = 0;
        end
        e         = '0;
        e.stall_D = 1'b1;
        e.fwdA    = model_fwd(s.rs_E, s);
        e.fwdB    = model_fwd(s.rt_E, s);
        e.done    = (m_mode == M_DONE);
        e.cnt     = CW'(m_cnt);
        lu = s.m2r_E && s.rw_E && s.wr_E != 0 &&
             (s.wr_E == s.rs_D || (s.uses_rt && s.wr_E == s.rt_D));
        jw = s.jr && s.rs_D != 0 &&
             ((s.rw_E && s.wr_E == s.rs_D) || (s.rw_M && s.wr_M == s.rs_D));
        if (m_mode == M_RUN) begin
            if (s.taken) begin
                e.pc_en = 1; e.pc_sel = 1; e.stall_D = 0;
                e.flush_D = 1; e.flush_E = 1; e.flush_M = 1;
            end else if (s.halt || lu || jw) begin
                e.flush_E = 1;
            end else if (s.jr) begin
                e.pc_en = 1; e.pc_sel = 3; e.stall_D = 0; e.flush_D = 1;
            end else if (s.jump) begin
                e.pc_en = 1; e.pc_sel = 2; e.stall_D = 0; e.flush_D = 1;
            end else begin
                e.pc_en = 1; e.stall_D = 0;
            end
        end else if (m_mode != M_IDLE) begin
            e.flush_E = 1;
        end
        q.push_back(e);

        if (!s.rst) begin
            case (m_mode)
                M_IDLE: if (s.start) m_mode = M_RUN;
                M_RUN: begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (!s.taken && s.halt) begin
                        m_mode  = M_DRAIN;
                        m_drain = DC;
                    end
                end
                M_DRAIN: begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_drain--;
                    if (m_drain == 0) m_mode = M_DONE;
                end
                default: ;
            endcase
        end
    endtask

    // Monitor: every queued expectation is checked mid-cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_en",       32'(pc_en),   32'(e.pc_en));
            chk("pc_sel",      32'(pc_sel),  32'(e.pc_sel));
            chk("stall_D",     32'(stall_D), 32'(e.stall_D));
            chk("flush_D",     32'(flush_D), 32'(e.flush_D));
            chk("flush_E",     32'(flush_E), 32'(e.flush_E));
            chk("flush_M",     32'(flush_M), 32'(e.flush_M));
            chk("fwdA_E",      32'(fwdA_E),  32'(e.fwdA));
            chk("fwdB_E",      32'(fwdB_E),  32'(e.fwdB));
            chk("done",        32'(done),    32'(e.done));
            chk("cycle_count", cycle_count,  e.cnt);
        end
    end

    initial begin
        stim_t s;
        // Reset, then a clean start.
        s = '0; s.rst = 1; step(s); step(s);
        s = '0; step(s); step(s);
        s.start = 1; step(s);
        // Plain ALU stream.
        s = '0;
        repeat (10) step(s);
        // lw $2 in E, add $3,$2,$4 in D: one bubble, then add in E forwards from W.
        s = '0; s.rw_E = 1; s.m2r_E = 1; s.wr_E = 2; s.rs_D = 2; s.rt_D = 4; s.uses_rt = 1;
        step(s);
        s = '0; s.rw_M = 1; s.wr_M = 2; step(s);
        s = '0; s.rw_W = 1; s.wr_W = 2; s.rs_E = 2; s.rt_E = 4; step(s);
        // Taken branch beats jump and halt in the same cycle.
        s = '0; s.taken = 1; s.jump = 1; s.halt = 1; step(s);
        s = '0; step(s);
        // jr $31 waiting on E, then M, then redirect.
        s = '0; s.jr = 1; s.rs_D = 31; s.rw_E = 1; s.wr_E = 31; step(s);
        s = '0; s.jr = 1; s.rs_D = 31; s.rw_M = 1; s.wr_M = 31; step(s);
        s = '0; s.jr = 1; s.rs_D = 31; s.rw_W = 1; s.wr_W = 31; step(s);
        // jr $0 never waits, even with $0 writers in flight.
        s = '0; s.jr = 1; s.rs_D = 0; s.rw_E = 1; s.wr_E = 0; s.rw_M = 1; s.wr_M = 0; step(s);
        // Double match: M beats W.
        s = '0; s.rw_M = 1; s.wr_M = 3; s.rw_W = 1; s.wr_W = 3; s.rs_E = 3; s.rt_E = 3; step(s);
        // Halt, drain, done; further start pulses ignored, count frozen.
        s = '0; s.halt = 1; step(s);
        s = '0; s.taken = 1; step(s);
        s = '0; repeat (3) step(s);
        s = '0; s.start = 1; repeat (4) step(s);
        // Reset mid-drain.
        s = '0; s.rst = 1; step(s);
        s = '0; s.start = 1; step(s);
        s = '0; repeat (3) step(s);
        s = '0; s.halt = 1; step(s);
        s = '0; step(s);
        s = '0; s.rst = 1; step(s);
        s = '0; step(s);

        // Randomized runs; some are cut by reset mid-drain.
        for (int run = 0; run < 8; run++) begin
            s = '0; s.rst = 1; step(s);
            s = '0; s.start = 1; step(s);
            for (int i = 0; i < 250; i++) begin
                s = rnd_stim((run % 2 == 0) ? 1 : 4);
                if ((run % 3 == 2) && m_mode == M_DRAIN && m_drain == 2)
                    s.rst = 1;
                else if ($urandom_range(0, 299) == 0)
                    s.rst = 1;
                step(s);
            end
        end

        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
